// File: rtl/truth_table_sweeper.sv
// Programmable N_VARS-input truth table (SOP or POS list) swept over every input vector.
// Optional macro SWEEP_ONES_COUNT_EN enables the per-sweep count of F=1 vectors.
module truth_table_sweeper #(
  parameter int N_VARS      = 4,
  parameter int STEP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [(1<<N_VARS)-1:0]    term_mask,
  input  logic                      pos_mode,
  input  logic                      start,
  input  logic                      hold,
  output logic                      busy,
  output logic [N_VARS-1:0]         vec,
  output logic                      vec_valid,
  output logic                      f_out,
  output logic                      done,
  output logic [N_VARS:0]           ones_count
);

  localparam int         N_TERMS   = 1 << N_VARS;
  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state;
  logic [N_TERMS-1:0] tbl_q;
  logic               pos_q;
  logic [7:0]         step_cnt;

  function automatic logic eval_f(input logic [N_TERMS-1:0] tbl,
                                  input logic               pos,
                                  input logic [N_VARS-1:0]  v);
    return tbl[v] ^ pos;
  endfunction

  // A load on the same edge as start must already drive the first vector.
  logic               ctrl_open;
  logic [N_TERMS-1:0] tbl_eff;
  logic               pos_eff;
  logic [N_VARS-1:0]  vec_nxt;
  logic               f_first;
  logic               f_next;

  assign ctrl_open = (state != SWEEP);
  assign tbl_eff   = (ctrl_open && load) ? term_mask : tbl_q;
  assign pos_eff   = (ctrl_open && load) ? pos_mode  : pos_q;
  assign vec_nxt   = vec + 1'b1;
  assign f_first   = eval_f(tbl_eff, pos_eff, '0);
  assign f_next    = eval_f(tbl_q, pos_q, vec_nxt);

`ifdef SWEEP_ONES_COUNT_EN
  logic [N_VARS:0] ones_q;
  assign ones_count = ones_q;
`else
  assign ones_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tbl_q     <= '0;
      pos_q     <= 1'b0;
      vec       <= '0;
      f_out     <= 1'b0;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
      step_cnt  <= '0;
`ifdef SWEEP_ONES_COUNT_EN
      ones_q    <= '0;
`endif
    end else begin
      vec_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            tbl_q <= term_mask;
            pos_q <= pos_mode;
          end
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            vec       <= '0;
            f_out     <= f_first;
            vec_valid <= 1'b1;
            step_cnt  <= '0;
`ifdef SWEEP_ONES_COUNT_EN
            ones_q    <= (N_VARS+1)'(f_first);
`endif
          end else begin
            state <= IDLE;
          end
        end
        SWEEP: begin
          if (!hold) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (vec == '1) begin
                // Terminal vector finished: vec/f_out keep their last values.
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                vec       <= vec_nxt;
                f_out     <= f_next;
                vec_valid <= 1'b1;
`ifdef SWEEP_ONES_COUNT_EN
                ones_q    <= ones_q + (N_VARS+1)'(f_next);
`endif
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (STEP_CYCLES 1 and 3), cycle model plus directed sweeps.
module tb_truth_table_sweeper;

`ifdef SWEEP_ONES_COUNT_EN
  localparam bit ONES_EN = 1'b1;
`else
  localparam bit ONES_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        load_s  [2];
  logic [15:0] mask_s  [2];
  logic        pos_s   [2];
  logic        start_s [2];
  logic        hold_s  [2];
  logic        busy_o  [2];
  logic [3:0]  vec_o   [2];
  logic        valid_o [2];
  logic        f_o     [2];
  logic        done_o  [2];
  logic [4:0]  ones_o  [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_VARS(4), .STEP_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst_s[0]), .load(load_s[0]), .term_mask(mask_s[0]),
    .pos_mode(pos_s[0]), .start(start_s[0]), .hold(hold_s[0]),
    .busy(busy_o[0]), .vec(vec_o[0]), .vec_valid(valid_o[0]),
    .f_out(f_o[0]), .done(done_o[0]), .ones_count(ones_o[0]));

  truth_table_sweeper #(.N_VARS(4), .STEP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst_s[1]), .load(load_s[1]), .term_mask(mask_s[1]),
    .pos_mode(pos_s[1]), .start(start_s[1]), .hold(hold_s[1]),
    .busy(busy_o[1]), .vec(vec_o[1]), .vec_valid(valid_o[1]),
    .f_out(f_o[1]), .done(done_o[1]), .ones_count(ones_o[1]));

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, i, $time, act, exp);
    end
  endtask

  function automatic int cnt_f(input logic [15:0] t, input bit p, input int upto);
    int c = 0;
    for (int v = 0; v <= upto; v++) if (t[v] ^ p) c++;
    return c;
  endfunction

  // Model: a sweep is a count n of non-held cycles; vector = n / S, pulse when n is a multiple of S
  // and the previous edge was not held; the sweep ends once n reaches 16*S.
  int          step_of [2] = '{1, 3};
  bit          m_sw    [2];
  int          m_n     [2];
  bit          m_ph    [2];
  bit          m_done  [2];
  logic [15:0] m_tbl   [2];
  bit          m_pos   [2];
  int          m_lastv [2];
  bit          m_lastf [2];
  int          m_lasto [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst_s[i]) begin
        m_sw[i] = 0; m_n[i] = 0; m_ph[i] = 0; m_tbl[i] = '0; m_pos[i] = 0;
        m_lastv[i] = 0; m_lastf[i] = 0; m_lasto[i] = 0;
      end else if (m_sw[i]) begin
        m_ph[i] = hold_s[i];
        if (!hold_s[i]) begin
          m_n[i]++;
          if (m_n[i] == 16 * step_of[i]) begin
            m_sw[i]    = 0;
            m_done[i]  = 1;
            m_lastv[i] = 15;
            m_lastf[i] = m_tbl[i][15] ^ m_pos[i];
            m_lasto[i] = cnt_f(m_tbl[i], m_pos[i], 15);
          end
        end
      end else begin
        if (load_s[i]) begin
          m_tbl[i] = mask_s[i];
          m_pos[i] = pos_s[i];
        end
        if (start_s[i]) begin
          m_sw[i] = 1; m_n[i] = 0; m_ph[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int  ev, eo;
        bit  ef, evl, eb;
        if (m_sw[i]) begin
          ev  = m_n[i] / step_of[i];
          ef  = m_tbl[i][ev] ^ m_pos[i];
          evl = (m_n[i] % step_of[i] == 0) && !m_ph[i];
          eb  = 1;
          eo  = cnt_f(m_tbl[i], m_pos[i], ev);
        end else begin
          ev = m_lastv[i]; ef = m_lastf[i]; evl = 0; eb = 0; eo = m_lasto[i];
        end
        if (!ONES_EN) eo = 0;
        chk("busy", i, 32'(busy_o[i]), 32'(eb));
        chk("vec", i, 32'(vec_o[i]), 32'(ev));
        chk("f_out", i, 32'(f_o[i]), 32'(ef));
        chk("vec_valid", i, 32'(valid_o[i]), 32'(evl));
        chk("done", i, 32'(done_o[i]), 32'(m_done[i]));
        chk("ones_count", i, 32'(ones_o[i]), 32'(eo));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives start (and optional load), then runs to the done pulse.
  task automatic sweep(input int i, input bit do_load, input logic [15:0] mask, input bit pos,
                       input int hold_at, input int hold_len, input int inj_at,
                       output logic [15:0] fseq, output int done_t, output int busy_n,
                       output int vec2_n, output logic [4:0] ones, output bit first_ok);
    int t = 0;
    int hold_left = 0;
    bit got = 0;
    fseq = 'x; done_t = 0; busy_n = 0; vec2_n = 0; ones = 'x; first_ok = 0;
    load_s[i] = do_load; mask_s[i] = mask; pos_s[i] = pos; start_s[i] = 1'b1;
    while (t < 400 && !got) begin
      @(negedge clk);
      t++;
      load_s[i] = 0; start_s[i] = 0; hold_s[i] = 0;
      if (t == 1) first_ok = busy_o[i] && valid_o[i] && (vec_o[i] == 4'd0);
      if (busy_o[i]) busy_n++;
      if (valid_o[i]) fseq[vec_o[i]] = f_o[i];
      if (busy_o[i] && vec_o[i] == 4'd2) vec2_n++;
      if (valid_o[i] && vec_o[i] == hold_at) hold_left = hold_len;
      if (hold_left > 0) begin
        hold_s[i] = 1; hold_left--;
      end
      if (valid_o[i] && vec_o[i] == inj_at) begin
        load_s[i] = 1; start_s[i] = 1; mask_s[i] = 16'hFFFF; pos_s[i] = 0;
      end
      if (done_o[i]) begin
        got = 1; done_t = t; ones = ones_o[i];
      end
    end
    chk("sweep_reached_done", i, 32'(got), 32'd1);
  endtask

  initial begin
    logic [15:0] fs;
    int dt, bn, v2;
    logic [4:0] on;
    bit fo;
    int waited;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1; load_s[i] = 0; mask_s[i] = '0; pos_s[i] = 0; start_s[i] = 0; hold_s[i] = 0;
    end
    idle(2);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
      chk("rst_vec", i, 32'(vec_o[i]), 32'd0);
      chk("rst_done", i, 32'(done_o[i]), 32'd0);
      chk("rst_ones", i, 32'(ones_o[i]), 32'd0);
    end
    chk_en = 1;
    rst_s[0] = 0; rst_s[1] = 0;
    idle(2);

    // POS table
    sweep(0, 1, 16'h5507, 1, -1, 0, -1, fs, dt, bn, v2, on, fo);
    chk("pos_fseq", 0, 32'(fs), 32'h0000AAF8);
    chk("pos_done_lat", 0, dt, 17);
    chk("pos_busy_cycles", 0, bn, 16);
    chk("pos_ones", 0, 32'(on), ONES_EN ? 32'd9 : 32'd0);
    idle(3);

    // SOP table
    sweep(0, 1, 16'h5507, 0, -1, 0, -1, fs, dt, bn, v2, on, fo);
    chk("sop_fseq", 0, 32'(fs), 32'h00005507);
    chk("sop_ones", 0, 32'(on), ONES_EN ? 32'd7 : 32'd0);
    idle(2);

    // load/start mid-sweep are ignored
    sweep(0, 1, 16'h5507, 1, -1, 0, 6, fs, dt, bn, v2, on, fo);
    chk("ign_fseq", 0, 32'(fs), 32'h0000AAF8);
    chk("ign_done_lat", 0, dt, 17);
    idle(2);
    sweep(0, 1, 16'hFFFF, 0, -1, 0, -1, fs, dt, bn, v2, on, fo);
    chk("all1_fseq", 0, 32'(fs), 32'h0000FFFF);
    chk("all1_ones", 0, 32'(on), ONES_EN ? 32'd16 : 32'd0);
    idle(2);

    // back-to-back: start (with new load) in the done cycle
    sweep(0, 1, 16'h5507, 1, -1, 0, -1, fs, dt, bn, v2, on, fo);
    sweep(0, 1, 16'h00F0, 0, -1, 0, -1, fs, dt, bn, v2, on, fo);
    chk("b2b_first", 0, 32'(fo), 32'd1);
    chk("b2b_fseq", 0, 32'(fs), 32'h000000F0);
    chk("b2b_done_lat", 0, dt, 17);
    idle(2);

    // reset mid-sweep at vec=5
    load_s[0] = 1; mask_s[0] = 16'h5507; pos_s[0] = 1; start_s[0] = 1;
    @(negedge clk);
    load_s[0] = 0; start_s[0] = 0;
    waited = 0;
    while (vec_o[0] != 4'd5 && waited < 50) begin
      @(negedge clk); waited++;
    end
    chk("rst_mid_reach5", 0, 32'(vec_o[0]), 32'd5);
    chk("rst_mid_f5", 0, 32'(f_o[0]), 32'd1);
    rst_s[0] = 1;
    @(negedge clk);
    rst_s[0] = 0;
    chk("rst_mid_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_mid_vec", 0, 32'(vec_o[0]), 32'd0);
    chk("rst_mid_f", 0, 32'(f_o[0]), 32'd0);
    chk("rst_mid_done", 0, 32'(done_o[0]), 32'd0);
    idle(2);
    sweep(0, 0, 16'h0000, 0, -1, 0, -1, fs, dt, bn, v2, on, fo);
    chk("post_rst_first", 0, 32'(fo), 32'd1);
    chk("post_rst_fseq", 0, 32'(fs), 32'h00000000);
    chk("post_rst_done_lat", 0, dt, 17);
    idle(2);

    // STEP_CYCLES=3 with hold of 4 cycles at vec=2
    sweep(1, 1, 16'h5507, 1, 2, 4, -1, fs, dt, bn, v2, on, fo);
    chk("hold_fseq", 1, 32'(fs), 32'h0000AAF8);
    chk("hold_vec2_cycles", 1, v2, 7);
    chk("hold_busy_cycles", 1, bn, 52);
    chk("hold_done_lat", 1, dt, 53);
    chk("hold_ones", 1, 32'(on), ONES_EN ? 32'd9 : 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised successor to the fixed 4-input product-of-maxterms function block.
- Holds a programmable truth table of N_VARS inputs, given as a minterm list (SOP) or a maxterm list (POS).
- On a start pulse, walks every input vector 0..2^N_VARS-1 in order and presents the vector with its registered function value, one vector per STEP_CYCLES clocks.
- Serves as a self-contained stimulus/response engine for function-evaluation labs and regression benches.

Parameters:
- N_VARS, 4, number of Boolean inputs; legal range 2..8; vector 0 maps MSB = variable A.
- STEP_CYCLES, 1, clocks each vector is held; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  latches term_mask and pos_mode; honoured only in IDLE or DONE.
- term_mask  input  2^N_VARS  bit k set = term k is listed.
- pos_mode  input  1  0 = mask lists minterms (F=1 there); 1 = mask lists maxterms (F=0 there).
- start  input  1  begins a sweep; honoured only in IDLE or DONE.
- hold  input  1  pauses the sweep while high.
- busy  output  1  high in SWEEP.
- vec  output  N_VARS  current input vector.
- vec_valid  output  1  one-cycle pulse on the first non-held cycle of each vector.
- f_out  output  1  function value for vec, registered with vec.
- done  output  1  one-cycle pulse after the last vector completes.
- ones_count  output  N_VARS+1  number of vectors with F=1 in the last sweep.

Behaviour:
- Reset:
  - Next edge with rst=1 forces state IDLE.
  - Clears table, pos_mode register, vec, f_out, busy, vec_valid, done, ones_count and the step counter to 0.
  - Reset mid-sweep aborts immediately, with no done pulse.
- Load:
  - In IDLE/DONE, a load edge registers term_mask and pos_mode.
  - Load in SWEEP is ignored; the table is stable for the whole sweep.
  - Load and start on the same edge: load takes effect first, so the sweep uses the new table.
- Function evaluation: F(v) = term_mask_reg[v] XOR pos_mode_reg.
- States IDLE, SWEEP, DONE:
  - IDLE --start--> SWEEP. The next cycle shows vec=0, f_out=F(0), vec_valid=1, busy=1. Latency start->first vec_valid is 1 clock.
  - In SWEEP, the step counter counts STEP_CYCLES clocks per vector, then vec increments and vec_valid pulses.
  - With hold=1, the step counter and vec freeze, vec_valid=0 and busy stays 1. Hold on the cycle a pulse would occur delays that pulse until hold drops.
  - After the hold period of vector 2^N_VARS-1 completes -> DONE: done=1 for one cycle, busy=0; vec and f_out keep the last values.
  - DONE -> IDLE on the next cycle unless start is high, which restarts at vec=0 (back-to-back sweeps, no gap beyond the DONE cycle).
  - start during SWEEP is ignored.
  - No wrap: vec never rolls from max back to 0 within one sweep.
- Widths: vec counter is N_VARS bits; terminal detection compares against all-ones. ones_count is N_VARS+1 bits so 2^N_VARS fits.

Optional Feature:
- Macro SWEEP_ONES_COUNT_EN.
- Defined:
  - ones_count clears to 0 on an accepted start and adds 1 for each vector whose F=1 at its vec_valid pulse.
  - Final value is stable from the done cycle until the next start or rst.
- Undefined: the counter logic is omitted and ones_count is tied to 0. The port remains, so benches compile unchanged.

Test Plan:
- Reset mid-sweep:
  - Stimulus: rst during SWEEP at vec=5.
  - Response: next cycle busy=0, vec=0, f_out=0, done stays 0, state IDLE. A fresh start then sweeps from 0.
- POS table:
  - Stimulus: N_VARS=4, STEP_CYCLES=1, load term_mask=16'h5507, pos_mode=1, start.
  - Response: f_out for vec 0..15 = 0,0,0,1,1,1,1,1,0,1,0,1,0,1,0,1.
  - done pulses 17 cycles after start; ones_count=9 when the macro is defined, 0 when undefined.
- SOP table:
  - Stimulus: same mask with pos_mode=0.
  - Response: the complemented sequence; ones_count=7 with the macro.
- Step and hold timing:
  - Stimulus: STEP_CYCLES=3; assert hold for 4 cycles while vec=2.
  - Response: vec_valid pulses every 3 cycles; vec stays 2 for 7 cycles; total sweep 16*3+4 cycles.
- Ignored controls during sweep:
  - Stimulus: load term_mask=16'hFFFF and a start pulse mid-sweep.
  - Response: no change to the remaining f_out values and no restart.
  - A subsequent load in IDLE plus start gives all f_out=1 and ones_count=16.
- Back-to-back start:
  - Stimulus: start asserted in the done cycle.
  - Response: the next cycle shows vec=0 with vec_valid=1 and no IDLE cycle. load+start on the same edge uses the new mask.
